// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: requester/consumer bus bundle for the shared Gray converter
interface gray_conv_arbiter_if #(
  parameter int W   = 4,
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   dout;
  logic [IDW-1:0] dout_id;
  logic           dout_valid;
  logic           out_ready;
  logic           busy;
  modport master (output req, din, out_ready, input gnt, dout, dout_id, dout_valid, busy);
  modport slave  (input req, din, out_ready, output gnt, dout, dout_id, dout_valid, busy);
endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter sharing one registered binary-to-Gray converter among N requesters
module gray_conv_arbiter #(
  parameter int W   = 4,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input logic                clk,
  input logic                rst_n,
  gray_conv_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] win_id_q, win_id_d;
  logic [W-1:0]   op_q, op_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   dout_q, dout_d;
  logic [IDW-1:0] dout_id_q, dout_id_d;
  logic           dout_valid_q, dout_valid_d;
  logic [IDW-1:0] win;
  always_comb begin
    win = rr_ptr_q;
    for (int i = N - 1; i >= 0; i--)
      if (bus.req[(int'(rr_ptr_q) + i) % N]) win = IDW'((int'(rr_ptr_q) + i) % N);
  end
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_id_d     = win_id_q;
    op_d         = op_q;
    gnt_d        = '0;
    dout_d       = dout_q;
    dout_id_d    = dout_id_q;
    dout_valid_d = dout_valid_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        op_d     = bus.din[int'(win)*W +: W];
        win_id_d = win;
        gnt_d    = N'(1) << win;
        state_d  = CONV;
      end
      CONV: begin
        dout_d       = op_q ^ (op_q >> 1);
        dout_id_d    = win_id_q;
        dout_valid_d = 1'b1;
        state_d      = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        dout_valid_d = 1'b0;
        rr_ptr_d     = IDW'((int'(win_id_q) + 1) % N);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      win_id_q     <= '0;
      op_q         <= '0;
      gnt_q        <= '0;
      dout_q       <= '0;
      dout_id_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_id_q     <= win_id_d;
      op_q         <= op_d;
      gnt_q        <= gnt_d;
      dout_q       <= dout_d;
      dout_id_q    <= dout_id_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_id    = dout_id_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed-vector self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  gray_conv_arbiter_if #(.W(4), .N(4), .IDW(2)) bus ();
  gray_conv_arbiter #(.W(4), .N(4), .IDW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, ".gnt"}, 32'(bus.gnt), 0);
    check({tag, ".dout"}, 32'(bus.dout), 0);
    check({tag, ".id"}, 32'(bus.dout_id), 0);
    check({tag, ".valid"}, 32'(bus.dout_valid), 0);
    check({tag, ".busy"}, 32'(bus.busy), 0);
  endtask
  task automatic txn(input string tag, input logic [3:0] r, input logic [15:0] d,
                     input int exp_id, input int exp_dout);
    bus.req       = r;
    bus.din       = d;
    bus.out_ready = 1'b1;
    step();
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(1 << exp_id));
    check({tag, ".busy"}, 32'(bus.busy), 1);
    step();
    check({tag, ".gnt0"}, 32'(bus.gnt), 0);
    check({tag, ".valid"}, 32'(bus.dout_valid), 1);
    check({tag, ".dout"}, 32'(bus.dout), 32'(exp_dout));
    check({tag, ".id"}, 32'(bus.dout_id), 32'(exp_id));
    step();
    check({tag, ".done"}, 32'(bus.dout_valid), 0);
    check({tag, ".idle"}, 32'(bus.busy), 0);
  endtask
  initial begin
    bus.req       = '0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    step();
    step();
    check_zero("rst");
    rst_n   = 1'b1;
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle.gnt", 32'(bus.gnt), 0);
      check("idle.busy", 32'(bus.busy), 0);
    end
    for (int v = 0; v < 16; v++)
      txn($sformatf("sweep%0d", v), 4'b0010, 16'(v << 4), 1, int'(gray_tbl[v]));
    do_reset();
    begin
      int ids [5] = '{0, 1, 2, 3, 0};
      int outs [5] = '{2, 4, 15, 8, 2};
      for (int t = 0; t < 5; t++)
        txn($sformatf("rr%0d", t), 4'b1111, 16'hFA73, ids[t], outs[t]);
    end
    bus.req       = 4'b0100;
    bus.din       = 16'h0500;
    bus.out_ready = 1'b0;
    step();
    check("bp.gnt", 32'(bus.gnt), 32'h4);
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp.valid", 32'(bus.dout_valid), 1);
      check("bp.dout", 32'(bus.dout), 7);
      check("bp.id", 32'(bus.dout_id), 2);
      check("bp.busy", 32'(bus.busy), 1);
      step();
      check("bp.gnt0", 32'(bus.gnt), 0);
    end
    bus.req       = '0;
    bus.out_ready = 1'b1;
    step();
    check("bp.acc", 32'(bus.dout_valid), 0);
    check("bp.idle", 32'(bus.busy), 0);
    check("bp.keep", 32'(bus.dout), 7);
    step();
    check("bp.nognt", 32'(bus.gnt), 0);
    txn("wrap3", 4'b1000, 16'h9000, 3, 13);
    txn("skip0", 4'b0101, 16'h0601, 0, 1);
    txn("skip2", 4'b0101, 16'h0601, 2, 5);
    txn("lone0a", 4'b0001, 16'h0004, 0, 6);
    txn("lone0b", 4'b0001, 16'h0004, 0, 6);
    bus.req       = 4'b0010;
    bus.din       = 16'h0020;
    bus.out_ready = 1'b0;
    step();
    check("rconv.gnt", 32'(bus.gnt), 32'h2);
    rst_n   = 1'b0;
    bus.req = '0;
    step();
    check_zero("rconv");
    rst_n = 1'b1;
    txn("rconv.rel", 4'b1000, 16'hA000, 3, 15);
    txn("pre", 4'b0001, 16'h0003, 0, 2);
    bus.req       = 4'b0100;
    bus.din       = 16'h0B00;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rhold.valid", 32'(bus.dout_valid), 1);
    check("rhold.dout", 32'(bus.dout), 14);
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b1;
    step();
    check_zero("rhold");
    rst_n = 1'b1;
    txn("rhold.rel", 4'b0011, 16'h00C5, 0, 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
